// File: rtl/arbitro_ram.sv
// arbitro_ram: two-requester round-robin sequencer in front of one
// single-port synchronous RAM (registered read, write on the clock edge).
// Accesses are serialised. Each access is granted, driven onto the memory
// port for one cycle, then completed with a valid pulse, read data and a
// range error flag.
//
//   state    | meaning
//   S_IDLE   | nothing in flight, waiting for any request
//   S_ACCESS | winner granted, memory port driven from the latched request
//   S_RESP   | read data present on mem_dato, result returned on exit
module arbitro_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] dir0,
  input  logic [ADDR_W-1:0] dir1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] dato0,
  output logic [DATA_W-1:0] dato1,
  output logic              valid0,
  output logic              valid1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_dato
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic              r_inr;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_valid0;
  logic              r_valid1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_dato0;
  logic [DATA_W-1:0] r_dato1;
  logic [ADDR_W-1:0] r_mem_dir;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_mem_we;
  logic              r_mem_en;

  logic              w_any_req;
  logic              w_win;
  logic              w_sel_we;
  logic              w_sel_inr;
  logic              w_launch;
  logic [ADDR_W-1:0] w_sel_dir;
  logic [DATA_W-1:0] w_sel_din;

  // Winner selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_any_req = req0 | req1;
    if (req0 && req1) begin
      w_win = ~r_last;
    end else begin
      w_win = req1;
    end
    w_sel_we  = w_win ? we1  : we0;
    w_sel_dir = w_win ? dir1 : dir0;
    w_sel_din = w_win ? din1 : din0;
    w_sel_inr = ({1'b0, w_sel_dir} < C_DEPTH);
    w_launch  = w_any_req && ((r_state == S_IDLE) || (r_state == S_RESP));
  end

  // Sequencer FSM; every output is a register so reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_inr     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_valid0  <= 1'b0;
      r_valid1  <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_dato0   <= '0;
      r_dato1   <= '0;
      r_mem_dir <= '0;
      r_mem_din <= '0;
      r_mem_we  <= 1'b0;
      r_mem_en  <= 1'b0;
    end else begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_ACCESS: begin
          r_state   <= S_RESP;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_mem_dir <= '0;
          r_mem_din <= '0;
          r_mem_we  <= 1'b0;
          r_mem_en  <= 1'b0;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (!r_win) begin
            r_valid0 <= 1'b1;
            r_err0   <= ~r_inr;
            if (!r_we) begin
              r_dato0 <= r_inr ? mem_dato : '0;
            end
          end else begin
            r_valid1 <= 1'b1;
            r_err1   <= ~r_inr;
            if (!r_we) begin
              r_dato1 <= r_inr ? mem_dato : '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Launch overrides the state-exit defaults above (IDLE or RESP only).
      if (w_launch) begin
        r_state   <= S_ACCESS;
        r_win     <= w_win;
        r_last    <= w_win;
        r_we      <= w_sel_we;
        r_inr     <= w_sel_inr;
        r_gnt0    <= ~w_win;
        r_gnt1    <= w_win;
        r_mem_dir <= w_sel_dir;
        r_mem_din <= w_sel_din;
        r_mem_en  <= w_sel_inr;
        r_mem_we  <= w_sel_we & w_sel_inr;
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign valid0  = r_valid0;
  assign valid1  = r_valid1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign dato0   = r_dato0;
  assign dato1   = r_dato1;
  assign mem_dir = r_mem_dir;
  assign mem_din = r_mem_din;
  assign mem_we  = r_mem_we;
  assign mem_en  = r_mem_en;

endmodule

// File: tb/tb_arbitro_ram.sv
// tb_arbitro_ram: scoreboard bench for arbitro_ram with an external RAM model.
module tb_arbitro_ram;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] dir0 = '0, dir1 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, valid0, valid1, err0, err1, mem_we, mem_en;
  logic [DW-1:0] dato0, dato1, mem_din;
  logic [AW-1:0] mem_dir;
  logic [DW-1:0] mem_dato = '0;

  always #5 clk = ~clk;

  arbitro_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .dir0(dir0), .dir1(dir1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .dato0(dato0), .dato1(dato1),
    .valid0(valid0), .valid1(valid1), .err0(err0), .err1(err1),
    .mem_dir(mem_dir), .mem_din(mem_din), .mem_we(mem_we), .mem_en(mem_en),
    .mem_dato(mem_dato)
  );

  // RAM model, cycle counter and request sampling at the arbitration edge
  logic [DW-1:0] mem [256];
  int   cyc = 0;
  logic s_req0 = 1'b0, s_req1 = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_req0 <= req0;
    s_req1 <= req1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i * 20);
    end else if (mem_en) begin
      if (mem_we) mem[mem_dir] <= mem_din;
      else        mem_dato <= mem[mem_dir];
    end
  end

  // reference model and scoreboard state
  int            total = 0, bad = 0;
  logic [DW:0]   q0[$], q1[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_dato [2];
  int            gnt_cyc [2];
  int            last_valid_cyc [2];
  logic          prev_g [2];
  int            last_win = 1;
  int            gseq[$];
  int            we_cnt = 0, en_cnt = 0;
  logic [AW-1:0] last_we_dir = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input int p, input logic g, input logic v, input logic [DW-1:0] d,
                          input logic er, input logic own_s, input logic oth_s);
    logic [DW:0] e;
    if (g) begin
      check($sformatf("gnt%0d_fair", p), 64'(own_s && !(last_win == p && oth_s)), 64'd1);
      check($sformatf("gnt%0d_pulse", p), 64'(prev_g[p]), 64'd0);
      last_win = p;
      gseq.push_back(p);
      gnt_cyc[p] = cyc;
    end
    if (v) begin
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL valid%0d_unexpected: got valid with no accepted request", p);
      end else begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dato%0d", p), 64'(d), 64'(e[DW-1:0]));
        check($sformatf("err%0d", p), 64'(er), 64'(e[DW]));
        check($sformatf("lat%0d", p), 64'(cyc - gnt_cyc[p]), 64'd2);
      end
      last_valid_cyc[p] = cyc;
    end
    prev_g[p] = g;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_win  = 1;
        prev_g[0] = 1'b0;
        prev_g[1] = 1'b0;
      end else begin
        if (gnt0 && gnt1) check("gnt_excl", 64'({gnt0, gnt1}), 64'd0);
        mon_port(0, gnt0, valid0, dato0, err0, s_req0, s_req1);
        mon_port(1, gnt1, valid1, dato1, err1, s_req1, s_req0);
        if (mem_en) begin
          en_cnt++;
          check("mem_en_range", 64'(mem_dir < DEPTH), 64'd1);
        end
        if (mem_we) begin
          we_cnt++;
          last_we_dir = mem_dir;
          check("mem_we_en", 64'(mem_en), 64'd1);
        end
      end
    end
  endtask

  // Issue one access, wait for its grant, then record the expected result.
  task automatic do_access(input int p, input logic we, input logic [AW-1:0] dir,
                           input logic [DW-1:0] din);
    logic got = 1'b0;
    logic oor;
    if (p == 0) begin req0 = 1'b1; we0 = we; dir0 = dir; din0 = din; end
    else        begin req1 = 1'b1; we1 = we; dir1 = dir; din1 = din; end
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? gnt0 : gnt1;
    end
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL gnt%0d_timeout: got no grant, required one within 60 cycles", p);
      return;
    end
    oor = (dir >= DEPTH);
    if (we) begin
      if (!oor) ref_mem[dir] = din;
    end else begin
      exp_dato[p] = oor ? '0 : ref_mem[dir];
    end
    if (p == 0) q0.push_back({oor, exp_dato[0]});
    else        q1.push_back({oor, exp_dato[1]});
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_dato[0] = '0;
    exp_dato[1] = '0;
    q0.delete();
    q1.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({gnt0, gnt1, valid0, valid1, err0, err1, dato0, dato1,
                mem_dir, mem_din, mem_we, mem_en});
  endfunction

  initial begin
    logic got;
    int   en_before, we_before;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 20);
    exp_dato[0] = '0; exp_dato[1] = '0;
    prev_g[0] = 1'b0; prev_g[1] = 1'b0;
    gnt_cyc[0] = 0; gnt_cyc[1] = 0;
    last_valid_cyc[0] = 0; last_valid_cyc[1] = 0;
    fork monitor(); join_none

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", all_outs(), 64'd0);

    // 1: basic read
    do_access(0, 1'b0, 8'd3, 8'd0);
    drain();
    check("t1_dato0", 64'(dato0), 64'd60);

    // 2: write then read back through requester 1
    we_before = we_cnt;
    do_access(1, 1'b1, 8'd5, 8'd77);
    drain();
    check("t2_we_cycles", 64'(we_cnt - we_before), 64'd1);
    check("t2_we_dir", 64'(last_we_dir), 64'd5);
    do_access(1, 1'b0, 8'd5, 8'd0);
    drain();
    check("t2_dato1", 64'(dato1), 64'd77);

    // 3: both requesters saturating after reset alternate, starting with 0
    do_reset();
    gseq.delete();
    fork
      for (int i = 0; i < 4; i++) do_access(0, 1'b0, AW'($urandom_range(0, 10)), 8'd0);
      for (int j = 0; j < 4; j++) do_access(1, 1'b0, AW'($urandom_range(0, 10)), 8'd0);
    join
    drain();
    check("t3_grants", 64'(gseq.size()), 64'd8);
    for (int i = 0; i < 8 && i < gseq.size(); i++)
      check($sformatf("t3_g%0d", i), 64'(gseq[i]), 64'(i % 2));

    // 4: out-of-range read never touches memory, last legal address works
    en_before = en_cnt;
    do_access(0, 1'b0, 8'd11, 8'd0);
    drain();
    check("t4_no_mem_en", 64'(en_cnt - en_before), 64'd0);
    check("t4_dato0_zero", 64'(dato0), 64'd0);
    do_access(0, 1'b0, 8'd10, 8'd0);
    drain();
    check("t4_dato0_last", 64'(dato0), 64'd200);

    // 5: reset during the ACCESS cycle of a write drops it
    req0 = 1'b1; we0 = 1'b1; dir0 = 8'd7; din0 = 8'd99;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = gnt0;
    end
    req0 = 1'b0;
    check("t5_gnt_seen", 64'(got), 64'd1);
    check("t5_we_before", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_drop", 64'({mem_we, mem_en, gnt0}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_dato[0] = '0; exp_dato[1] = '0;
    @(negedge clk);
    check("t5_outs_after", all_outs(), 64'd0);
    repeat (4) @(negedge clk);
    do_access(0, 1'b0, 8'd7, 8'd0);
    drain();
    check("t5_not_written", 64'(dato0), 64'd140);

    // 6: write from 0 queued behind a read from 1
    do_access(1, 1'b0, 8'd5, 8'd0);
    do_access(0, 1'b1, 8'd5, 8'd33);
    drain();
    check("t6_gnt0_at_valid1", 64'(gnt_cyc[0] - last_valid_cyc[1]), 64'd0);
    check("t6_dato1_held", 64'(dato1), 64'd77);
    do_access(0, 1'b0, 8'd5, 8'd0);
    drain();

    // random mixed traffic from both requesters
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_access(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 13)), DW'($urandom));
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_access(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 13)), DW'($urandom));
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
